// File: rtl/cga_mic_pkg.sv
// Shared definitions for the microcode return stack.
// Operation codes and per-row select codes.
package cga_mic_pkg;

   localparam logic [1:0] OP_HOLD    = 2'b00;
   localparam logic [1:0] OP_PUSH    = 2'b01;
   localparam logic [1:0] OP_POP     = 2'b10;
   localparam logic [1:0] OP_REPLACE = 2'b11;

   typedef enum logic [1:0] {
      SEL_HOLD  = 2'b00,
      SEL_ABOVE = 2'b01,
      SEL_BELOW = 2'b10,
      SEL_DIN   = 2'b11
   } sel_t;

endpackage

// File: rtl/cga_mic_stack_entry.sv
// One stack row: keeps its value, shifts from a neighbour,
// or loads new data, with synchronous reset.
module cga_mic_stack_entry
   import cga_mic_pkg::*;
#(
   parameter int WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  sel_t             sel,
   input  logic [WIDTH-1:0] din,
   input  logic [WIDTH-1:0] above,
   input  logic [WIDTH-1:0] below,
   output logic [WIDTH-1:0] q
);

   // Row register with select-driven next value.
   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else begin
         unique case (sel)
            SEL_HOLD:  q <= q;
            SEL_ABOVE: q <= above;
            SEL_BELOW: q <= below;
            SEL_DIN:   q <= din;
         endcase
      end
   end

endmodule

// File: rtl/cga_mic_return_stack.sv
// Microcode return-address stack with shifting rows,
// saturating depth counter and sticky overflow/underflow flags.
module cga_mic_return_stack
   import cga_mic_pkg::*;
#(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [1:0]                 OP,
   input  logic [WIDTH-1:0]           DIN,
   input  logic                       CLR_ERR,
   output logic [WIDTH-1:0]           TOS,
   output logic [WIDTH-1:0]           NOS,
   output logic [$clog2(DEPTH+1)-1:0] COUNT,
   output logic                       EMPTY,
   output logic                       FULL,
   output logic                       OVF,
   output logic                       UNF
);

   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] e [DEPTH];
   sel_t             sel [DEPTH];
   logic             ovf_set;
   logic             unf_set;

   assign TOS   = e[0];
   assign NOS   = e[1];
   assign EMPTY = (COUNT == '0);
   assign FULL  = (COUNT == CW'(DEPTH));

   assign ovf_set = (OP == OP_PUSH) && FULL;
   assign unf_set = (OP == OP_POP) && EMPTY;

   // Per-row select; the bottom row recirculates on pop.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         sel[i] = SEL_HOLD;
         unique case (OP)
            OP_HOLD:    sel[i] = SEL_HOLD;
            OP_PUSH:    sel[i] = (i == 0) ? SEL_DIN : SEL_ABOVE;
            OP_POP:     sel[i] = (i == DEPTH-1) ? SEL_HOLD : SEL_BELOW;
            OP_REPLACE: sel[i] = (i == 0) ? SEL_DIN : SEL_HOLD;
         endcase
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_row
      logic [WIDTH-1:0] above;
      logic [WIDTH-1:0] below;

      if (g == 0) begin : g_top
         assign above = DIN;
      end else begin : g_mid
         assign above = e[g-1];
      end

      if (g == DEPTH-1) begin : g_bot
         assign below = e[g];
      end else begin : g_up
         assign below = e[g+1];
      end

      cga_mic_stack_entry #(
         .WIDTH (WIDTH)
      ) u_entry (
         .clk   (CLK),
         .rst   (RST),
         .sel   (sel[g]),
         .din   (DIN),
         .above (above),
         .below (below),
         .q     (e[g])
      );
   end

   // Depth counter and sticky flags; a new error beats a clear.
   always_ff @(posedge CLK) begin
      if (RST) begin
         COUNT <= '0;
         OVF   <= 1'b0;
         UNF   <= 1'b0;
      end else begin
         OVF <= (OVF & ~CLR_ERR) | ovf_set;
         UNF <= (UNF & ~CLR_ERR) | unf_set;
         if (OP == OP_PUSH && !FULL) begin
            COUNT <= COUNT + CW'(1);
         end else if (OP == OP_POP && !EMPTY) begin
            COUNT <= COUNT - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_cga_mic_return_stack.sv
// Bench for the return stack: directed table at depth 4,
// random streams against a reference model at depths 2 and 16.
module tb_cga_mic_return_stack;
   import cga_mic_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // depth-4 instance
   logic        rst4 = 1'b1;
   logic [1:0]  op4 = OP_HOLD;
   logic [11:0] din4 = '0;
   logic        clr4 = 1'b0;
   logic [11:0] tos4, nos4;
   logic [2:0]  cnt4;
   logic        emp4, full4, ovf4, unf4;

   cga_mic_return_stack #(.WIDTH(12), .DEPTH(4)) u4 (
      .CLK(clk), .RST(rst4), .OP(op4), .DIN(din4), .CLR_ERR(clr4),
      .TOS(tos4), .NOS(nos4), .COUNT(cnt4), .EMPTY(emp4),
      .FULL(full4), .OVF(ovf4), .UNF(unf4)
   );

   // depth-2 and depth-16 instances share random stimulus
   logic        rstr = 1'b1;
   logic [1:0]  opr = OP_HOLD;
   logic [11:0] dinr = '0;
   logic        clrr = 1'b0;
   logic [11:0] tos2, nos2, tos16, nos16;
   logic [1:0]  cnt2;
   logic [4:0]  cnt16;
   logic        emp2, full2, ovf2, unf2;
   logic        emp16, full16, ovf16, unf16;

   cga_mic_return_stack #(.WIDTH(12), .DEPTH(2)) u2 (
      .CLK(clk), .RST(rstr), .OP(opr), .DIN(dinr), .CLR_ERR(clrr),
      .TOS(tos2), .NOS(nos2), .COUNT(cnt2), .EMPTY(emp2),
      .FULL(full2), .OVF(ovf2), .UNF(unf2)
   );

   cga_mic_return_stack #(.WIDTH(12), .DEPTH(16)) u16 (
      .CLK(clk), .RST(rstr), .OP(opr), .DIN(dinr), .CLR_ERR(clrr),
      .TOS(tos16), .NOS(nos16), .COUNT(cnt16), .EMPTY(emp16),
      .FULL(full16), .OVF(ovf16), .UNF(unf16)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic [1:0]  op;
      logic [11:0] din;
      logic        clr;
      logic [11:0] tos;
      logic [11:0] nos;
      logic [2:0]  cnt;
      logic        emp;
      logic        full;
      logic        ovf;
      logic        unf;
   } vec_t;

   vec_t vt [33];

   // reference model: index 0 is depth 2, index 1 is depth 16
   logic [11:0] mdl [2][16];
   int          mcnt [2];
   bit          movf [2];
   bit          munf [2];
   int          mdep [2] = '{2, 16};

   task automatic mstep(input int k, input logic [1:0] op,
                        input logic [11:0] din, input bit clr);
      int d;
      bit so, su;
      d  = mdep[k];
      so = 1'b0;
      su = 1'b0;
      case (op)
         OP_PUSH: begin
            for (int i = d - 1; i > 0; i--) mdl[k][i] = mdl[k][i-1];
            mdl[k][0] = din;
            if (mcnt[k] == d) so = 1'b1;
            else mcnt[k]++;
         end
         OP_POP: begin
            for (int i = 0; i < d - 1; i++) mdl[k][i] = mdl[k][i+1];
            if (mcnt[k] == 0) su = 1'b1;
            else mcnt[k]--;
         end
         OP_REPLACE: mdl[k][0] = din;
         default: ;
      endcase
      movf[k] = (clr ? 1'b0 : movf[k]) | so;
      munf[k] = (clr ? 1'b0 : munf[k]) | su;
   endtask

   function automatic vec_t mk(input logic r, input logic [1:0] o,
      input logic [11:0] d, input logic c, input logic [11:0] t,
      input logic [11:0] n, input logic [2:0] cn, input logic f,
      input logic ov, input logic un);
      vec_t v;
      v.rst = r; v.op = o; v.din = d; v.clr = c;
      v.tos = t; v.nos = n; v.cnt = cn;
      v.emp = (cn == 3'd0); v.full = f; v.ovf = ov; v.unf = un;
      return v;
   endfunction

   initial begin
      // reset, fill, overflow, drain
      vt[0]  = mk(1, OP_PUSH,    12'hFFF, 0, 12'h000, 12'h000, 0, 0, 0, 0);
      vt[1]  = mk(0, OP_PUSH,    12'h101, 0, 12'h101, 12'h000, 1, 0, 0, 0);
      vt[2]  = mk(0, OP_PUSH,    12'h202, 0, 12'h202, 12'h101, 2, 0, 0, 0);
      vt[3]  = mk(0, OP_PUSH,    12'h303, 0, 12'h303, 12'h202, 3, 0, 0, 0);
      vt[4]  = mk(0, OP_PUSH,    12'h404, 0, 12'h404, 12'h303, 4, 1, 0, 0);
      vt[5]  = mk(0, OP_PUSH,    12'h505, 0, 12'h505, 12'h404, 4, 1, 1, 0);
      vt[6]  = mk(0, OP_POP,     12'h000, 0, 12'h404, 12'h303, 3, 0, 1, 0);
      vt[7]  = mk(0, OP_POP,     12'h000, 0, 12'h303, 12'h202, 2, 0, 1, 0);
      vt[8]  = mk(0, OP_POP,     12'h000, 0, 12'h202, 12'h202, 1, 0, 1, 0);
      vt[9]  = mk(0, OP_POP,     12'h000, 0, 12'h202, 12'h202, 0, 0, 1, 0);
      vt[10] = mk(0, OP_HOLD,    12'h000, 1, 12'h202, 12'h202, 0, 0, 0, 0);
      // underflow and clear
      vt[11] = mk(1, OP_HOLD,    12'h000, 0, 12'h000, 12'h000, 0, 0, 0, 0);
      vt[12] = mk(0, OP_POP,     12'h000, 0, 12'h000, 12'h000, 0, 0, 0, 1);
      vt[13] = mk(0, OP_HOLD,    12'h000, 1, 12'h000, 12'h000, 0, 0, 0, 0);
      // replace, clear racing underflow
      vt[14] = mk(0, OP_PUSH,    12'h0AA, 0, 12'h0AA, 12'h000, 1, 0, 0, 0);
      vt[15] = mk(0, OP_REPLACE, 12'h0BB, 0, 12'h0BB, 12'h000, 1, 0, 0, 0);
      vt[16] = mk(0, OP_POP,     12'h000, 1, 12'h000, 12'h000, 0, 0, 0, 0);
      vt[17] = mk(0, OP_POP,     12'h000, 1, 12'h000, 12'h000, 0, 0, 0, 1);
      // overflow set wins, other flag clears
      vt[18] = mk(0, OP_PUSH,    12'h011, 0, 12'h011, 12'h000, 1, 0, 0, 1);
      vt[19] = mk(0, OP_PUSH,    12'h022, 0, 12'h022, 12'h011, 2, 0, 0, 1);
      vt[20] = mk(0, OP_PUSH,    12'h033, 0, 12'h033, 12'h022, 3, 0, 0, 1);
      vt[21] = mk(0, OP_PUSH,    12'h044, 0, 12'h044, 12'h033, 4, 1, 0, 1);
      vt[22] = mk(0, OP_PUSH,    12'h055, 0, 12'h055, 12'h044, 4, 1, 1, 1);
      vt[23] = mk(0, OP_PUSH,    12'h066, 1, 12'h066, 12'h055, 4, 1, 1, 0);
      vt[24] = mk(0, OP_REPLACE, 12'h077, 1, 12'h077, 12'h055, 4, 1, 0, 0);
      vt[25] = mk(0, OP_HOLD,    12'h0FF, 0, 12'h077, 12'h055, 4, 1, 0, 0);
      vt[26] = mk(0, OP_POP,     12'h000, 0, 12'h055, 12'h044, 3, 0, 0, 0);
      vt[27] = mk(0, OP_POP,     12'h000, 0, 12'h044, 12'h033, 2, 0, 0, 0);
      // mid-sequence reset discards the push
      vt[28] = mk(1, OP_PUSH,    12'hFFF, 0, 12'h000, 12'h000, 0, 0, 0, 0);
      vt[29] = mk(0, OP_PUSH,    12'h123, 0, 12'h123, 12'h000, 1, 0, 0, 0);
      vt[30] = mk(0, OP_PUSH,    12'h456, 0, 12'h456, 12'h123, 2, 0, 0, 0);
      vt[31] = mk(0, OP_POP,     12'h000, 0, 12'h123, 12'h000, 1, 0, 0, 0);
      vt[32] = mk(0, OP_REPLACE, 12'h7E1, 0, 12'h7E1, 12'h000, 1, 0, 0, 0);

      for (int i = 0; i < 33; i++) begin
         rst4 = vt[i].rst; op4 = vt[i].op;
         din4 = vt[i].din; clr4 = vt[i].clr;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d tos", i),   32'(tos4),  32'(vt[i].tos));
         chk($sformatf("v%0d nos", i),   32'(nos4),  32'(vt[i].nos));
         chk($sformatf("v%0d count", i), 32'(cnt4),  32'(vt[i].cnt));
         chk($sformatf("v%0d empty", i), 32'(emp4),  32'(vt[i].emp));
         chk($sformatf("v%0d full", i),  32'(full4), 32'(vt[i].full));
         chk($sformatf("v%0d ovf", i),   32'(ovf4),  32'(vt[i].ovf));
         chk($sformatf("v%0d unf", i),   32'(unf4),  32'(vt[i].unf));
      end

      // inputs must not reach TOS/NOS before the edge
      op4 = OP_PUSH; din4 = 12'h3AB; clr4 = 1'b0;
      #2;
      chk("comb tos", 32'(tos4), 32'h7E1);
      chk("comb nos", 32'(nos4), 32'h000);
      @(posedge clk);
      #1;
      chk("reg tos", 32'(tos4), 32'h3AB);
      chk("reg nos", 32'(nos4), 32'h7E1);
      op4 = OP_HOLD;

      // random streams, depths 2 and 16
      for (int k = 0; k < 2; k++) begin
         mcnt[k] = 0; movf[k] = 0; munf[k] = 0;
         for (int i = 0; i < 16; i++) mdl[k][i] = '0;
      end
      rstr = 1'b1;
      @(posedge clk);
      #1;
      rstr = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         opr  = 2'($urandom_range(0, 3));
         dinr = 12'($urandom);
         clrr = ($urandom_range(0, 15) == 0);
         @(posedge clk);
         mstep(0, opr, dinr, clrr);
         mstep(1, opr, dinr, clrr);
         #1;
         chk($sformatf("d2 c%0d tos", c),   32'(tos2),  32'(mdl[0][0]));
         chk($sformatf("d2 c%0d nos", c),   32'(nos2),  32'(mdl[0][1]));
         chk($sformatf("d2 c%0d count", c), 32'(cnt2),  32'(mcnt[0]));
         chk($sformatf("d2 c%0d ovf", c),   32'(ovf2),  32'(movf[0]));
         chk($sformatf("d2 c%0d unf", c),   32'(unf2),  32'(munf[0]));
         chk($sformatf("d16 c%0d tos", c),   32'(tos16), 32'(mdl[1][0]));
         chk($sformatf("d16 c%0d nos", c),   32'(nos16), 32'(mdl[1][1]));
         chk($sformatf("d16 c%0d count", c), 32'(cnt16), 32'(mcnt[1]));
         chk($sformatf("d16 c%0d ovf", c),   32'(ovf16), 32'(movf[1]));
         chk($sformatf("d16 c%0d unf", c),   32'(unf16), 32'(munf[1]));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
